// File: rtl/battle_hp_datapath.sv
// rtl/battle_hp_datapath.sv - HP, potion and LFSR datapath under the battle FSM (optional BATTLE_CRIT_HIT_EN)
module battle_hp_datapath #(
  parameter int HP_W      = 8,
  parameter int P_MAX_HP  = 100,
  parameter int AI_MAX_HP = 100,
  parameter int BASE_DMG  = 10,
  parameter int HEAL_AMT  = 20,
  parameter int POTIONS   = 3,
  parameter int CATCH_HP  = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_ai_hp,
  input  logic            apply_ai_damage,
  input  logic            apply_p_damage,
  input  logic            p_heal,
  input  logic            catch,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [2:0]      potions_left,
  output logic            ai_dead,
  output logic            p_dead,
  output logic            catch_success,
  output logic            crit
);

  localparam logic [HP_W:0]   BASE_V     = (HP_W+1)'(BASE_DMG);
  localparam logic [HP_W:0]   HEAL_V     = (HP_W+1)'(HEAL_AMT);
  localparam logic [HP_W:0]   P_MAX_WIDE = (HP_W+1)'(P_MAX_HP);
  localparam logic [HP_W-1:0] P_MAX_V    = HP_W'(P_MAX_HP);
  localparam logic [HP_W-1:0] AI_MAX_V   = HP_W'(AI_MAX_HP);
  localparam logic [HP_W-1:0] CATCH_V    = HP_W'(CATCH_HP);
  localparam logic [2:0]      POT_V      = 3'(POTIONS);
  localparam logic [7:0]      SEED       = 8'hA5;

  logic [7:0]      lfsr;
  logic            frozen;
  logic [HP_W:0]   dmg_ai;
  logic [HP_W:0]   dmg_p;
  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] heal_hp;

  // HP subtraction that floors at zero instead of wrapping
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W:0] dmg);
    if ({1'b0, hp} <= dmg) return '0;
    return hp - dmg[HP_W-1:0];
  endfunction

  assign ai_dead       = (ai_hp == '0);
  assign p_dead        = (p_hp == '0);
  assign frozen        = ai_dead | p_dead;
  assign catch_success = catch & ((ai_hp <= CATCH_V) | (lfsr[2:0] == 3'd0));

  // Hit sizes from independent LFSR fields, doubled on a critical roll when enabled
  always_comb begin
    dmg_ai = BASE_V + (HP_W+1)'(lfsr[2:0]);
    dmg_p  = BASE_V + (HP_W+1)'(lfsr[5:3]);
`ifdef BATTLE_CRIT_HIT_EN
    if (lfsr[7:6] == 2'b11) begin
      dmg_ai = dmg_ai << 1;
      dmg_p  = dmg_p << 1;
    end
`endif
  end

  // Potion result clamped to the player's max HP
  always_comb begin
    heal_sum = {1'b0, p_hp} + HEAL_V;
    heal_hp  = (heal_sum > P_MAX_WIDE) ? P_MAX_V : heal_sum[HP_W-1:0];
  end

  // HP, potion and LFSR state; reload beats AI damage, player damage beats heal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr         <= SEED;
      p_hp         <= P_MAX_V;
      ai_hp        <= AI_MAX_V;
      potions_left <= POT_V;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (load_ai_hp)
        ai_hp <= AI_MAX_V;
      else if (apply_ai_damage && !frozen)
        ai_hp <= sat_sub(ai_hp, dmg_ai);
      if (!frozen) begin
        if (apply_p_damage) begin
          p_hp <= sat_sub(p_hp, dmg_p);
        end else if (p_heal && potions_left != 3'd0) begin
          p_hp         <= heal_hp;
          potions_left <= potions_left - 3'd1;
        end
      end
    end
  end

`ifdef BATTLE_CRIT_HIT_EN
  // One-cycle flag after any doubled hit actually lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      crit <= 1'b0;
    else
      crit <= (lfsr[7:6] == 2'b11) && !frozen &&
              ((apply_ai_damage && !load_ai_hp) || apply_p_damage);
  end
`else
  assign crit = 1'b0;
`endif

endmodule

// File: tb/tb_battle_hp_datapath.sv
// tb/tb_battle_hp_datapath.sv - randomized model-checked bench for battle_hp_datapath
module tb_battle_hp_datapath;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_ai_hp = 1'b0;
  logic       apply_ai_damage = 1'b0;
  logic       apply_p_damage = 1'b0;
  logic       p_heal = 1'b0;
  logic       catch = 1'b0;
  logic [7:0] p_hp;
  logic [7:0] ai_hp;
  logic [2:0] potions_left;
  logic       ai_dead;
  logic       p_dead;
  logic       catch_success;
  logic       crit;

  int n_chk = 0;
  int n_fail = 0;

  int m_p, m_ai, m_pot, m_lfsr, m_crit;

  battle_hp_datapath dut (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp),
    .apply_ai_damage(apply_ai_damage), .apply_p_damage(apply_p_damage),
    .p_heal(p_heal), .catch(catch), .p_hp(p_hp), .ai_hp(ai_hp),
    .potions_left(potions_left), .ai_dead(ai_dead), .p_dead(p_dead),
    .catch_success(catch_success), .crit(crit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_crit_roll();
`ifdef BATTLE_CRIT_HIT_EN
    return ((m_lfsr >> 6) & 3) == 3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_p = 100; m_ai = 100; m_pot = 3; m_lfsr = 'hA5; m_crit = 0;
  endtask

  task automatic model_step();
    bit dead, roll;
    int dai, dp;
    dead = (m_ai == 0) || (m_p == 0);
    roll = model_crit_roll();
    dai  = 10 + (m_lfsr & 7);
    dp   = 10 + ((m_lfsr >> 3) & 7);
    if (roll) begin dai = 2 * dai; dp = 2 * dp; end
    m_crit = (roll && !dead && ((apply_ai_damage && !load_ai_hp) || apply_p_damage)) ? 1 : 0;
    if (load_ai_hp) m_ai = 100;
    else if (apply_ai_damage && !dead) m_ai = (m_ai > dai) ? m_ai - dai : 0;
    if (!dead) begin
      if (apply_p_damage) m_p = (m_p > dp) ? m_p - dp : 0;
      else if (p_heal && m_pot > 0) begin
        m_p = (m_p + 20 > 100) ? 100 : m_p + 20;
        m_pot--;
      end
    end
    m_lfsr = ((m_lfsr << 1) & 'hFE) |
             (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
  endtask

  task automatic compare_all();
    int exp_catch;
    exp_catch = (catch && (m_ai <= 20 || (m_lfsr & 7) == 0)) ? 1 : 0;
    chk("p_hp", p_hp, m_p);
    chk("ai_hp", ai_hp, m_ai);
    chk("potions_left", potions_left, m_pot);
    chk("ai_dead", ai_dead, m_ai == 0);
    chk("p_dead", p_dead, m_p == 0);
    chk("catch_success", catch_success, exp_catch);
    chk("crit", crit, m_crit);
  endtask

  task automatic drive(input bit ld, input bit ad, input bit pd, input bit ph, input bit ct);
    load_ai_hp = ld; apply_ai_damage = ad; apply_p_damage = pd; p_heal = ph; catch = ct;
  endtask

  // Called just after a falling edge: drive, check, let the rising edge act, return at next falling edge
  task automatic cycle(input bit ld, input bit ad, input bit pd, input bit ph, input bit ct);
    drive(ld, ad, pd, ph, ct);
    #1 compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Reset dropped between edges with strobes still high; values must restore before any edge
  task automatic mid_reset();
    drive(1'($urandom), 1'b1, 1'b1, 1'b1, 1'($urandom));
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int before_p, before_ai, exp_hit, guard;

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    chk("reset_p_hp", p_hp, 100);
    chk("reset_ai_hp", ai_hp, 100);
    chk("reset_potions", potions_left, 3);
    chk("reset_flags", {ai_dead, p_dead, catch_success, crit}, 0);

    drive(0, 1, 1, 0, 1);
    #1 chk("catch_full_hp", catch_success, 0);
    @(posedge clk); model_step(); @(negedge clk);
    chk("first_hit_ai", ai_hp, 85);
    chk("first_hit_p", p_hp, 86);
    chk("first_hit_crit", crit, 0);

    cycle(0, 0, 0, 1, 0);
    chk("heal_clamp_p", p_hp, 100);
    chk("heal_clamp_pot", potions_left, 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    chk("heal_exhaust_pot", potions_left, 0);
    chk("heal_exhaust_p", p_hp, 100);

    guard = 0;
    while (m_ai != 0 && guard < 30) begin cycle(0, 1, 0, 0, 0); guard++; end
    chk("ai_sat_zero", ai_hp, 0);
    chk("ai_dead_set", ai_dead, 1);
    drive(0, 0, 0, 0, 1);
    #1 chk("catch_low_hp", catch_success, 1);
    before_p = p_hp;
    @(negedge clk);
    cycle(0, 0, 1, 1, 0);
    chk("freeze_p", p_hp, before_p);
    cycle(1, 0, 0, 0, 0);
    chk("reload_ai", ai_hp, 100);
    chk("reload_dead", ai_dead, 0);

    mid_reset();
    chk("midreset_p", p_hp, 100);
    chk("midreset_pot", potions_left, 3);

`ifdef BATTLE_CRIT_HIT_EN
    guard = 0;
    while (((m_lfsr >> 6) & 3) != 3 && guard < 60) begin cycle(0, 0, 0, 0, 0); guard++; end
    before_ai = ai_hp;
    exp_hit = 2 * (10 + (m_lfsr & 7));
    cycle(0, 1, 0, 0, 0);
    chk("crit_ai", ai_hp, (before_ai > exp_hit) ? before_ai - exp_hit : 0);
    chk("crit_flag", crit, 1);
    cycle(0, 0, 0, 0, 0);
    chk("crit_pulse_end", crit, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) mid_reset();
      else cycle($urandom_range(99) < 8, $urandom_range(99) < 40,
                 $urandom_range(99) < 25, $urandom_range(99) < 20,
                 $urandom_range(99) < 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/battle_hp_datapath.md
# battle_hp_datapath

Battle datapath directly downstream of the battle control FSM. It holds both Pokémon's HP, potion stock and a pseudo-random source. It applies the FSM's per-state strobes (damage, heal, catch, AI reload) and returns the status flags the FSM branches on: `ai_dead`, `p_dead` and `catch_success`. All flags are derived from registered state, so the FSM can consume them combinationally in the same cycle.

## Interface
Parameters:
- `HP_W`, 8: HP register width.
- `P_MAX_HP`, 100: player HP after reset.
- `AI_MAX_HP`, 100: AI HP after reset and after `load_ai_hp`.
- `BASE_DMG`, 10: fixed part of each hit.
- `HEAL_AMT`, 20: HP restored per potion.
- `POTIONS`, 3: potions available after reset; `POTIONS` ≤ 7.
- `CATCH_HP`, 20: AI HP at or below which a catch always succeeds.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `load_ai_hp` in 1: reload AI HP to max.
- `apply_ai_damage` in 1: player hits AI.
- `apply_p_damage` in 1: AI hits player.
- `p_heal` in 1: player drinks a potion.
- `catch` in 1: catch attempt this cycle.
- `p_hp` out HP_W: player HP register.
- `ai_hp` out HP_W: AI HP register.
- `potions_left` out 3: remaining potions.
- `ai_dead` out 1: `ai_hp == 0`.
- `p_dead` out 1: `p_hp == 0`.
- `catch_success` out 1: catch attempt succeeds this cycle.
- `crit` out 1: registered, high for the cycle after a critical hit is applied.

## Operation
- **LFSR.** 8-bit Fibonacci LFSR.
  - Seed 8'hA5.
  - Update every cycle: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - It never reaches 0.
- **Damage.** All operands are zero-extended to HP_W+1 bits.
  - `dmg_ai = BASE_DMG + lfsr[2:0]`.
  - `dmg_p = BASE_DMG + lfsr[5:3]`.
  - Subtraction saturates at 0; HP never wraps.
- **Heal.**
  - Applies only if `potions_left != 0`.
  - `p_hp <= min(p_hp + HEAL_AMT, P_MAX_HP)`; the addition is HP_W+1 wide.
  - `potions_left` decrements by 1.
  - With `potions_left == 0` the heal is ignored: no change, no decrement.
- **Catch.** Combinational from registers and the input: `catch_success = catch & (ai_hp <= CATCH_HP | lfsr[2:0] == 0)`. No state changes on a catch.
- **Reload.** `load_ai_hp` sets `ai_hp <= AI_MAX_HP`. It is the only update honoured while dead.
- **Freeze.** While `ai_dead | p_dead`, damage and heal strobes are ignored.
- **Simultaneous events.**
  - `apply_ai_damage` and `apply_p_damage` both apply in the same cycle, using independent LFSR fields.
  - `load_ai_hp` overrides `apply_ai_damage`.
  - `apply_p_damage` overrides `p_heal`; the potion is not consumed.
- **Strobe level.** Strobes are level signals. Each high cycle is one action, so a strobe held 2 cycles applies twice.

## Timing
- **Reset values (async):**
  - `p_hp = P_MAX_HP`
  - `ai_hp = AI_MAX_HP`
  - `potions_left = POTIONS`
  - `lfsr = 8'hA5`
  - `crit = 0`
  - Derived: `ai_dead = 0`, `p_dead = 0`, `catch_success = 0`.
- **Reset mid-battle.** Asserting `reset_n` low restores all of the above immediately, regardless of pending strobes.
- **Update latency.** A strobe in cycle N uses the cycle-N `lfsr` and HP values. New HP is visible in N+1.
- **Dead flags.** `ai_dead` / `p_dead` rise in N+1, the same cycle the HP register reads 0.
- **`catch_success`.** Valid in the same cycle as `catch`, zero latency.

## Configuration
- **`BATTLE_CRIT_HIT_EN` defined:** when `lfsr[7:6] == 2'b11` in the strobe cycle, the applied damage is doubled. Doubling uses HP_W+1 bits, then saturates. `crit` pulses for 1 cycle in N+1.
- **`BATTLE_CRIT_HIT_EN` undefined:** damage is never doubled and `crit` is tied to 0.

## Test plan
- **Reset values.** Apply reset, release it, sample in cycle 0 → `p_hp = 100`, `ai_hp = 100`, `potions_left = 3`, all flags 0.
- **Simultaneous hits.** Assert `apply_ai_damage` and `apply_p_damage` together in the first cycle after reset (`lfsr = A5`) → next cycle `ai_hp = 85`, `p_hp = 86`, `crit = 0`.
- **Saturation and freeze.** Preload `ai_hp = 3` via repeated hits, then hit → `ai_hp = 0`, `ai_dead = 1`. Then `apply_p_damage` and `p_heal` → `p_hp` unchanged. Then `load_ai_hp` → `ai_hp = 100`, `ai_dead = 0`.
- **Heal clamp and exhaustion.** From `p_hp = 90`, heal → `p_hp = 100`, `potions_left = 2`. Heal 3 more times → `potions_left = 0`; the fourth heal changes nothing.
- **Catch.** With `ai_hp = 100` and `lfsr = A5`, assert `catch` → `catch_success = 0` in that cycle. With `ai_hp = 20`, assert `catch` → `catch_success = 1` in that cycle.
- **Reset mid-battle and crit.**
  - Reset asserted mid-battle (between clock edges, with a strobe high) → immediate restoration of reset values.
  - With `BATTLE_CRIT_HIT_EN` defined, on the first cycle with `lfsr[7:6] == 11` an AI hit removes `2*(10 + lfsr[2:0])` and `crit` = 1 for one cycle.
